// File: rtl/decode_hazard_stage.sv
// ID stage: control decode, register file with WB write-through, load-use hazard
// detection with one-cycle stall, branch flush, and the ID/EX pipeline register.
module decode_hazard_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_4,
    input  logic [31:0]       instr,
    input  logic [4:0]        write_reg_MEMWB,
    input  logic [DATA_W-1:0] write_data_WB,
    input  logic              write_en,
    input  logic              flush,
    output logic              stall,
    output logic              valid_IDEX,
    output logic [1:0]        wb_IDEX,
    output logic [2:0]        mem_IDEX,
    output logic [1:0]        aluop_IDEX,
    output logic              alusrc_IDEX,
    output logic              regdst_IDEX,
    output logic [31:0]       pc_4_IDEX,
    output logic [DATA_W-1:0] rs_IDEX,
    output logic [DATA_W-1:0] rt_IDEX,
    output logic [DATA_W-1:0] signExt_IDEX,
    output logic [4:0]        instr25_21_IDEX,
    output logic [4:0]        instr20_16_IDEX,
    output logic [4:0]        instr15_11_IDEX
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic [1:0] wb;      // {RegWrite, MemtoReg}
        logic [2:0] mem;     // {Branch, MemRead, MemWrite}
        logic [1:0] aluop;
        logic       alusrc;
        logic       regdst;
    } ctrl_t;

    logic [5:0] opcode;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic [4:0] rd_addr;

    assign opcode  = instr[31:26];
    assign rs_addr = instr[25:21];
    assign rt_addr = instr[20:16];
    assign rd_addr = instr[15:11];

    ctrl_t ctrl_d;
    logic  uses_rt;

    // NOTE: combinational blocks use blocking '=' with a default assigned first,
    // so every path drives every output and no latch is inferred.
    always_comb begin
        ctrl_d  = '0;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_d  = '{wb: 2'b10, mem: 3'b000, aluop: 2'b10, alusrc: 1'b0, regdst: 1'b1};
                uses_rt = 1'b1;
            end
            OP_LW:   ctrl_d = '{wb: 2'b11, mem: 3'b010, aluop: 2'b00, alusrc: 1'b1, regdst: 1'b0};
            OP_SW: begin
                ctrl_d  = '{wb: 2'b00, mem: 3'b001, aluop: 2'b00, alusrc: 1'b1, regdst: 1'b0};
                uses_rt = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d  = '{wb: 2'b00, mem: 3'b100, aluop: 2'b01, alusrc: 1'b0, regdst: 1'b0};
                uses_rt = 1'b1;
            end
            OP_ADDI: ctrl_d = '{wb: 2'b10, mem: 3'b000, aluop: 2'b00, alusrc: 1'b1, regdst: 1'b0};
            default: ctrl_d = '0;
        endcase
    end

    // A write lands only on an implemented register that is not the hardwired zero.
    logic wr_qual;
    assign wr_qual = write_en
                  && (int'(write_reg_MEMWB) < NUM_REGS)
                  && !(ZERO_REG && (write_reg_MEMWB == 5'd0));

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // NOTE: the register file is cleared on reset because software may read a
    // register before writing it; this rules out a RAM macro, which is acceptable
    // for a flop-based file of this size.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_qual) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(write_reg_MEMWB) == i) begin
                    regs_q[i] <= write_data_WB;
                end
            end
        end
    end

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    // Out-of-range indices match no entry and fall through to zero.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rs_addr) == i) rs_val = regs_q[i];
            if (int'(rt_addr) == i) rt_val = regs_q[i];
        end
        if (wr_qual && (write_reg_MEMWB == rs_addr)) rs_val = write_data_WB;
        if (wr_qual && (write_reg_MEMWB == rt_addr)) rt_val = write_data_WB;
        if (ZERO_REG && (rs_addr == 5'd0)) rs_val = '0;
        if (ZERO_REG && (rt_addr == 5'd0)) rt_val = '0;
    end

    logic [DATA_W-1:0] sext_val;
    assign sext_val = {{(DATA_W-16){instr[15]}}, instr[15:0]};

    logic              valid_q;
    ctrl_t             ctrl_q;
    logic [31:0]       pc_4_q;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic [DATA_W-1:0] sext_q;
    logic [4:0]        rs_field_q;
    logic [4:0]        rt_field_q;
    logic [4:0]        rd_field_q;

    // A load in EX whose destination is a source of the instruction in ID.
    logic load_use;
    logic bubble;
    assign load_use = valid_q && ctrl_q.mem[1] && (rt_field_q != 5'd0)
                   && ((rt_field_q == rs_addr) || (uses_rt && (rt_field_q == rt_addr)));
    assign stall    = load_use && !flush;
    assign bubble   = flush || stall;

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_4_q     <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            sext_q     <= '0;
            rs_field_q <= '0;
            rt_field_q <= '0;
            rd_field_q <= '0;
        end else begin
            valid_q    <= !bubble;
            ctrl_q     <= bubble ? ctrl_t'('0) : ctrl_d;
            pc_4_q     <= pc_4;
            rs_q       <= rs_val;
            rt_q       <= rt_val;
            sext_q     <= sext_val;
            rs_field_q <= rs_addr;
            rt_field_q <= rt_addr;
            rd_field_q <= rd_addr;
        end
    end

    assign valid_IDEX      = valid_q;
    assign wb_IDEX         = ctrl_q.wb;
    assign mem_IDEX        = ctrl_q.mem;
    assign aluop_IDEX      = ctrl_q.aluop;
    assign alusrc_IDEX     = ctrl_q.alusrc;
    assign regdst_IDEX     = ctrl_q.regdst;
    assign pc_4_IDEX       = pc_4_q;
    assign rs_IDEX         = rs_q;
    assign rt_IDEX         = rt_q;
    assign signExt_IDEX    = sext_q;
    assign instr25_21_IDEX = rs_field_q;
    assign instr20_16_IDEX = rt_field_q;
    assign instr15_11_IDEX = rd_field_q;

endmodule
